clk_div_monitor: RTL

Measurement-side counterpart to the clock divider/strobe generators. It samples one divided clock, `clk_mon`, on every rising edge of `clk_in`. Each full period it reports the period and high time in `clk_in` cycles and checks both against expected values. It sits beside the divider bank and provides on-chip self-check and lock indication for any divided output.

---
 rtl/clk_mon_pkg.sv | 14 +
 rtl/mon_edge_det.sv | 21 ++
 rtl/clk_div_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types for divided-clock monitors.
// State encoding and sticky error bit positions.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } mon_state_t;

  localparam int ERR_MISMATCH = 0;
  localparam int ERR_OVF      = 1;

endpackage

// File: rtl/mon_edge_det.sv
// Sample register and rising-edge detect for a clock
// derived from clk_in; no synchronizer is needed.
module mon_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic s_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) s_q <= 1'b0;
    else     s_q <= d;
  end

  assign s    = d;
  assign rise = d & ~s_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock,
// checks them against expected values and reports lock.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 28,
  parameter int EXP_HIGH   = 14,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_mon,
  input  logic             en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic [1:0]       err
);

  localparam int LW = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

  localparam logic signed [CNT_W:0] EP =
    (CNT_W + 1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] EH =
    (CNT_W + 1)'(EXP_HIGH);
  localparam logic signed [CNT_W:0] TL =
    (CNT_W + 1)'(TOL);

  mon_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [LW-1:0]    lock_cnt;

  logic s;
  logic rise;

  mon_edge_det u_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (clk_mon),
    .s      (s),
    .rise   (rise)
  );

  logic signed [CNT_W:0] dp;
  logic signed [CNT_W:0] dh;
  logic signed [CNT_W:0] ap;
  logic signed [CNT_W:0] ah;
  logic                  good;

  assign dp = $signed({1'b0, cnt}) - EP;
  assign dh = $signed({1'b0, hcnt}) - EH;
  assign ap = dp[CNT_W] ? -dp : dp;
  assign ah = dh[CNT_W] ? -dh : dh;
  assign good = (ap <= TL) && (ah <= TL);

  logic ovf;
  logic [1:0] err_set;

  assign ovf = !rise && (cnt == CNT_MAX);

  always_comb begin
    err_set = '0;
    if (en) begin
      if (state != IDLE && ovf)
        err_set[ERR_OVF] = 1'b1;
      if (state == MEAS && rise && !good)
        err_set[ERR_MISMATCH] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      lock_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= '0;
    end else begin
      meas_valid <= 1'b0;
      err <= (err_clr ? 2'b00 : err) | err_set;
      if (!en) begin
        state    <= IDLE;
        cnt      <= '0;
        hcnt     <= '0;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
            hcnt  <= '0;
          end
          // partial first period is thrown away
          ARM: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              hcnt  <= CNT_W'(1);
              state <= MEAS;
            end else if (ovf) begin
              cnt      <= '0;
              lock_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MEAS: begin
            if (rise) begin
              period     <= cnt;
              high_time  <= hcnt;
              meas_valid <= 1'b1;
              cnt        <= CNT_W'(1);
              hcnt       <= CNT_W'(1);
              if (good) begin
                if (lock_cnt != LOCK_MAX)
                  lock_cnt <= lock_cnt + 1'b1;
                locked <= (lock_cnt >= LOCK_MAX - 1'b1);
              end else begin
                lock_cnt <= '0;
                locked   <= 1'b0;
              end
            end else if (ovf) begin
              cnt      <= '0;
              hcnt     <= '0;
              lock_cnt <= '0;
              locked   <= 1'b0;
              state    <= ARM;
            end else begin
              cnt  <= cnt + 1'b1;
              hcnt <= hcnt + CNT_W'(s);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
